// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one registered 12-bit adder among up to four requesters.
// Optional feature macro: ADD_MOD_REDUCE_EN (single-step modular reduction of the sum by MODULUS).
module adder_share_arbiter #(
  parameter int REQ_N   = 4,
  parameter int WIDTH   = 12
`ifdef ADD_MOD_REDUCE_EN
  ,
  parameter int MODULUS = 4093
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_N-1:0]         req,
  input  logic [REQ_N*WIDTH-1:0]   a_in,
  input  logic [REQ_N*WIDTH-1:0]   b_in,
  input  logic                     hold,
  output logic [REQ_N-1:0]         gnt,
  output logic                     res_valid,
  output logic [1:0]               res_id,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic                     busy
);

  localparam int NIBBLES = WIDTH / 4;

  // One 4-bit carry stage of the shared adder.
  function automatic logic [4:0] add_nibble(input logic [3:0] x, input logic [3:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  logic [3:0]       elig_s;
  logic             grant_s;
  logic [1:0]       win_s;
  logic [1:0]       cand_s;
  logic [1:0]       ptr_r;
  logic [1:0]       ptr_next_s;
  logic             s1_vld_r;
  logic [1:0]       s1_id_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH:0]   sum_s;
  logic [4:0]       nib_s;
  logic             chain_c_s;
  logic [WIDTH-1:0] res_next_s;
  logic             carry_next_s;

  // Stage 0: search eligible requesters starting at ptr, wrapping modulo REQ_N.
  always_comb begin
    elig_s             = 4'b0000;
    elig_s[REQ_N-1:0]  = req & ~gnt;
    grant_s            = 1'b0;
    win_s              = 2'd0;
    cand_s             = ptr_r;
    for (int j = 0; j < REQ_N; j++) begin
      if (!grant_s && elig_s[cand_s]) begin
        grant_s = 1'b1;
        win_s   = cand_s;
      end else begin
        grant_s = grant_s;
      end
      if (cand_s == 2'(REQ_N - 1)) begin
        cand_s = 2'd0;
      end else begin
        cand_s = cand_s + 2'd1;
      end
    end
    if (hold) begin
      grant_s = 1'b0;
    end else begin
      grant_s = grant_s;
    end
    if (win_s == 2'(REQ_N - 1)) begin
      ptr_next_s = 2'd0;
    end else begin
      ptr_next_s = win_s + 2'd1;
    end
  end

  // Stage 1: issue the grant pulse, capture the winner's operands, advance the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= {REQ_N{1'b0}};
      s1_vld_r <= 1'b0;
      s1_id_r  <= 2'd0;
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      ptr_r    <= 2'd0;
    end else if (grant_s) begin
      gnt      <= {{(REQ_N-1){1'b0}}, 1'b1} << win_s;
      s1_vld_r <= 1'b1;
      s1_id_r  <= win_s;
      op_a_r   <= a_in[int'(win_s)*WIDTH +: WIDTH];
      op_b_r   <= b_in[int'(win_s)*WIDTH +: WIDTH];
      ptr_r    <= ptr_next_s;
    end else begin
      gnt      <= {REQ_N{1'b0}};
      s1_vld_r <= 1'b0;
    end
  end

  // Shared adder: nibble carry chain with carry-in tied low, plus optional reduction.
  always_comb begin
    sum_s     = {(WIDTH+1){1'b0}};
    nib_s     = 5'b00000;
    chain_c_s = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      nib_s            = add_nibble(op_a_r[n*4 +: 4], op_b_r[n*4 +: 4], chain_c_s);
      sum_s[n*4 +: 4]  = nib_s[3:0];
      chain_c_s        = nib_s[4];
    end
    sum_s[WIDTH] = chain_c_s;
`ifdef ADD_MOD_REDUCE_EN
    if (sum_s >= (WIDTH+1)'(MODULUS)) begin
      res_next_s   = WIDTH'(sum_s - (WIDTH+1)'(MODULUS));
      carry_next_s = 1'b1;
    end else begin
      res_next_s   = sum_s[WIDTH-1:0];
      carry_next_s = 1'b0;
    end
`else
    res_next_s   = sum_s[WIDTH-1:0];
    carry_next_s = sum_s[WIDTH];
`endif
  end

  // Stage 2: result registers load on a valid stage-1 entry and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      result    <= {WIDTH{1'b0}};
      carry_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= s1_vld_r;
      busy      <= grant_s | s1_vld_r;
      if (s1_vld_r) begin
        res_id    <= s1_id_r;
        result    <= res_next_s;
        carry_out <= carry_next_s;
      end else begin
        res_id    <= res_id;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (default configuration, REQ_N=4, WIDTH=12).
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] a_in;
  logic [47:0] b_in;
  logic        hold;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [11:0] result;
  logic        carry_out;
  logic        busy;

  int checks;
  int failures;

  adder_share_arbiter #(.REQ_N(4), .WIDTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .hold(hold),
    .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .result(result),
    .carry_out(carry_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    a_in[i*12 +: 12] = a;
    b_in[i*12 +: 12] = b;
  endtask

  logic [1:0]  order [8];
  logic [11:0] rr_sum [4];
  logic [11:0] wrap_res;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req = 4'b0000; hold = 1'b0; a_in = 48'd0; b_in = 48'd0;
    order  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_sum = '{12'h101, 12'h202, 12'h303, 12'h404};
`ifdef ADD_MOD_REDUCE_EN
    wrap_res = 12'h003;
`else
    wrap_res = 12'h000;
`endif
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(res_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single request from requester 0.
    @(negedge clk);
    req = 4'b0001; set_op(0, 12'h123, 12'h456);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_rv_early", 32'(res_valid), 32'h0);
    chk("t1_busy1", 32'(busy), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_gnt_off", 32'(gnt), 32'h0);
    chk("t1_rv", 32'(res_valid), 32'h1);
    chk("t1_id", 32'(res_id), 32'h0);
    chk("t1_result", 32'(result), 32'h579);
    chk("t1_carry", 32'(carry_out), 32'h0);
    chk("t1_busy2", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_rv_off", 32'(res_valid), 32'h0);
    chk("t1_busy_off", 32'(busy), 32'h0);

    // Overflow from requester 1 (ptr is now 1).
    req = 4'b0010; set_op(1, 12'hFFF, 12'h001);
    @(negedge clk);
    chk("ovf_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("ovf_id", 32'(res_id), 32'h1);
    chk("ovf_result", 32'(result), 32'(wrap_res));
    chk("ovf_carry", 32'(carry_out), 32'h1);

    // All four requesting: round robin from ptr=2.
    for (int i = 0; i < 4; i++) set_op(i, 12'((i + 1) * 256), 12'(i + 1));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << order[i]));
      if (i > 0) begin
        chk("rr_rv", 32'(res_valid), 32'h1);
        chk("rr_id", 32'(res_id), 32'(order[i-1]));
        chk("rr_result", 32'(result), 32'(rr_sum[order[i-1]]));
      end
    end
    req = 4'b0000;
    @(negedge clk);
    chk("rr_gnt_end", 32'(gnt), 32'h0);
    chk("rr_rv_last", 32'(res_valid), 32'h1);
    chk("rr_id_last", 32'(res_id), 32'(order[7]));
    @(negedge clk);
    chk("rr_rv_end", 32'(res_valid), 32'h0);

    // Single requester 2 held: granted on alternate edges.
    set_op(2, 12'h7FF, 12'h001);
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("solo_gnt", 32'(gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
      chk("solo_rv", 32'(res_valid), (i % 2 == 1) ? 32'h1 : 32'h0);
      if (i % 2 == 1) begin
        chk("solo_id", 32'(res_id), 32'h2);
        chk("solo_result", 32'(result), 32'h800);
      end
      if (i == 4) req = 4'b0000;
    end

    // Hold blocks grants; ptr (3) must not move, so 1 then 2 follow release.
    set_op(1, 12'h0AA, 12'h055);
    hold = 1'b1; req = 4'b0110;
    repeat (2) begin
      @(negedge clk);
      chk("hold_gnt", 32'(gnt), 32'h0);
      chk("hold_busy", 32'(busy), 32'h0);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("rel_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    chk("rel_gnt2", 32'(gnt), 32'h4);
    chk("rel_id1", 32'(res_id), 32'h1);
    chk("rel_res1", 32'(result), 32'h0FF);
    req = 4'b0000;
    @(negedge clk);
    chk("rel_id2", 32'(res_id), 32'h2);
    chk("rel_res2", 32'(result), 32'h800);

    // Asynchronous reset while an operation sits in stage 1.
    @(negedge clk);
    req = 4'b0001; set_op(0, 12'h111, 12'h222);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_id", 32'(res_id), 32'h0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_rv", 32'(res_valid), 32'h0);
    end
    set_op(3, 12'h010, 12'h020);
    set_op(0, 12'h001, 12'h002);
    req = 4'b1000;
    @(negedge clk);
    chk("post_gnt3", 32'(gnt), 32'h8);
    req = 4'b1001;
    @(negedge clk);
    chk("post_gnt0", 32'(gnt), 32'h1);
    chk("post_id3", 32'(res_id), 32'h3);
    chk("post_res3", 32'(result), 32'h030);
    req = 4'b0000;
    @(negedge clk);
    chk("post_id0", 32'(res_id), 32'h0);
    chk("post_res0", 32'(result), 32'h003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
